div_clock: RTL and testbench
============================

// Module: div_clock
// PURPOSE
//   Fixed-ratio clock divider producing a slow square wave (default 1 Hz) from
//   the 50 MHz system clock (20 ns period).
//   Drives low-rate logic (LED blink, seconds counters) in the top level.
//   Output is a registered, glitch-free signal intended as a data/enable-level
//   signal, not a routed clock tree.
// PARAMETERS
//   CLK_FREQ_HZ  50_000_000  input clock frequency in Hz
//   OUT_FREQ_HZ  1           output frequency in Hz
//   DIV   (localparam) = CLK_FREQ_HZ/OUT_FREQ_HZ, integer division; clk cycles per output period
//   LOW   (localparam) = DIV/2 (floor); cycles clk_1hz is low per period
//   HIGH  (localparam) = DIV-LOW; cycles clk_1hz is high per period
//   CW    (localparam) = max(1,$clog2(DIV)); counter width
// PORTS
//   clk      in   1   system clock, all logic on rising edge
//   rst      in   1   asynchronous, active-low reset (0 = reset)
//   clk_1hz  out  1   divided square wave, registered
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-low.
//   - Elaboration: DIV < 2 or OUT_FREQ_HZ = 0 -> $error/fatal; no silent fallback.
//   - Reset (rst=0): cnt and clk_1hz forced to 0 immediately, independent of clk.
//     Held while rst=0. Deassertion is synchronised externally.
//   - Reset mid-operation: any phase aborted; restart from cnt=0, clk_1hz=0.
//   - Counter: cnt (CW bits) increments every clk edge with rst=1.
//     It wraps DIV-1 -> 0 and never holds a value >= DIV.
//   - Output: clk_1hz <= (cnt_next >= LOW), registered, no combinational path to the port.
//   - Timing, numbering edges k=1,2,... after rst deasserts:
//     - clk_1hz rises after edge LOW and falls after edge DIV.
//     - It then repeats with period DIV exactly; no drift and no dropped or extra cycle at wrap.
//   - Duty cycle:
//     - even DIV: exactly 50%.
//     - odd DIV: high phase one cycle longer than low (e.g. DIV=7: low 3, high 4).
//   - Default: LOW=HIGH=25_000_000 cycles -> 0.5 s low, 0.5 s high.
//   - No enable, no runtime ratio change; no X on output after reset.
// TESTING
//   1 Reset: rst=0 mid-high-phase, asynchronously (between clk edges)
//     -> clk_1hz=0 within same timestep, cnt=0.
//   2 Even ratio (CLK_FREQ_HZ=10, OUT_FREQ_HZ=1), release rst
//     -> clk_1hz 0 for edges 1-4, 1 after edge 5, 0 after edge 10.
//     Period 10 cycles over >=5 periods.
//   3 Odd ratio (CLK_FREQ_HZ=7, OUT_FREQ_HZ=1)
//     -> low 3 cycles, high 4 cycles, period 7, repeated >=5 periods.
//   4 Minimum DIV=2 (CLK_FREQ_HZ=2)
//     -> clk_1hz toggles every clk edge after reset; DIV=1 fails elaboration.
//   5 Default params, 20 ns clk: hold rst=0 100 ns, release
//     -> first rise at 500 ms (+/- one clk), fall at 1 s.
//     Counter never exceeds 49_999_999.
//   6 Reset pulse after 3.5 periods (small params)
//     -> waveform restarts identical to scenario 2 from release.

Source files
------------

// File: rtl/div_clock.sv
// ----------------------------------------------------------------------------
// div_clock
//   Fixed-ratio divider that turns the system clock into a slow square wave
//   (1 Hz from 50 MHz by default). The output is a registered level meant to
//   drive low-rate logic such as an LED blink or a seconds counter. It is not
//   meant to be routed as a clock.
//
//   One output period lasts DIV = CLK_FREQ_HZ / OUT_FREQ_HZ input cycles:
//   LOW = DIV/2 cycles low, then HIGH = DIV - LOW cycles high. When DIV is
//   odd, the high phase is the longer one.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low (0 = reset)
//   clk_1hz  out  divided square wave, driven straight from a flop
// ----------------------------------------------------------------------------
module div_clock #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int OUT_FREQ_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    output logic clk_1hz
);

    // Guard the division so that a zero output frequency reaches the
    // elaboration check below and does not fault inside a constant divide.
    localparam int DIV  = (OUT_FREQ_HZ > 0) ? (CLK_FREQ_HZ / OUT_FREQ_HZ) : 0;
    localparam int LOW  = DIV / 2;
    localparam int HIGH = DIV - LOW;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LOW = CW'(LOW);

    if (OUT_FREQ_HZ <= 0 || DIV < 2 || HIGH < LOW) begin : g_bad_ratio
        $fatal(1, "div_clock: unusable ratio CLK_FREQ_HZ=%0d OUT_FREQ_HZ=%0d (DIV=%0d)",
               CLK_FREQ_HZ, OUT_FREQ_HZ, DIV);
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_1hz_q, clk_1hz_d;

    always_comb begin
        cnt_d     = cnt_q;
        clk_1hz_d = clk_1hz_q;
        // Wrap at DIV-1 so the count never reaches DIV. This holds even when
        // DIV is not a power of two.
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Decode from the next count so the registered output lines up with
        // the counter: the output is high after edge LOW and low after edge DIV.
        clk_1hz_d = (cnt_d >= CNT_LOW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            clk_1hz_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_1hz_q <= clk_1hz_d;
        end
    end

    assign clk_1hz = clk_1hz_q;

endmodule

// File: tb/tb_div_clock.sv
module tb_div_clock;

    logic clk;
    logic rst;
    logic o10, o7, o2, o100, odef;

    int total_cnt;
    int pass_cnt;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    div_clock #(.CLK_FREQ_HZ(10),   .OUT_FREQ_HZ(1))  u_d10  (.clk(clk), .rst(rst), .clk_1hz(o10));
    div_clock #(.CLK_FREQ_HZ(7),    .OUT_FREQ_HZ(1))  u_d7   (.clk(clk), .rst(rst), .clk_1hz(o7));
    div_clock #(.CLK_FREQ_HZ(2),    .OUT_FREQ_HZ(1))  u_d2   (.clk(clk), .rst(rst), .clk_1hz(o2));
    div_clock #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(10)) u_d100 (.clk(clk), .rst(rst), .clk_1hz(o100));
    div_clock                                         u_def  (.clk(clk), .rst(rst), .clk_1hz(odef));

    // Assert reset on a falling edge and hold it for n cycles. Release it on
    // a falling edge too, so the next rising edge is edge k=1.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset(5);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({o10, o7, o2, o100, odef} !== 5'b0) begin
            $display("FAIL reset_outputs: got %b want 00000", {o10, o7, o2, o100, odef});
        end else pass_cnt++;
        total_cnt++;
        if (u_d10.cnt_q !== 4'd0 || u_def.cnt_q !== 26'd0) begin
            $display("FAIL reset_cnt: got d10=%0d def=%0d want 0", u_d10.cnt_q, u_def.cnt_q);
        end else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_even;
        logic exp_v;
        do_reset(3);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            exp_v = ((k % 10) >= 5);
            total_cnt++;
            if (o10 !== exp_v || u_d10.cnt_q !== 4'(k % 10)) begin
                $display("FAIL even_div10 edge %0d: got out=%b cnt=%0d want out=%b cnt=%0d",
                         k, o10, u_d10.cnt_q, exp_v, k % 10);
            end else pass_cnt++;
        end
    endtask

    task automatic test_odd;
        logic exp_v;
        do_reset(3);
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk);
            #1;
            exp_v = ((k % 7) >= 3);
            total_cnt++;
            if (o7 !== exp_v) begin
                $display("FAIL odd_div7 edge %0d: got %b want %b", k, o7, exp_v);
            end else pass_cnt++;
        end
    endtask

    task automatic test_min_div;
        logic exp_v;
        do_reset(3);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            exp_v = ((k % 2) == 1);
            total_cnt++;
            if (o2 !== exp_v) begin
                $display("FAIL min_div2 edge %0d: got %b want %b", k, o2, exp_v);
            end else pass_cnt++;
        end
    endtask

    // DIV=100 scaled stand-in for the long default run. The default instance
    // is only checked for its first cycles: it must stay low and count up.
    task automatic test_scaled_and_default;
        logic exp_v;
        do_reset(5);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            exp_v = ((k % 100) >= 50);
            total_cnt++;
            if (o100 !== exp_v) begin
                $display("FAIL scaled_div100 edge %0d: got %b want %b", k, o100, exp_v);
            end else pass_cnt++;
            if (k % 50 == 0) begin
                total_cnt++;
                if (odef !== 1'b0 || u_def.cnt_q !== 26'(k)) begin
                    $display("FAIL default_early edge %0d: got out=%b cnt=%0d want out=0 cnt=%0d",
                             k, odef, u_def.cnt_q, k);
                end else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_mid_high;
        do_reset(3);
        repeat (7) @(posedge clk);
        #1;
        total_cnt++;
        if (o10 !== 1'b1) begin
            $display("FAIL async_pre_high: got %b want 1", o10);
        end else pass_cnt++;
        #4;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (o10 !== 1'b0 || u_d10.cnt_q !== 4'd0) begin
            $display("FAIL async_reset_mid_high: got out=%b cnt=%0d want out=0 cnt=0", o10, u_d10.cnt_q);
        end else pass_cnt++;
        @(negedge clk);
        @(posedge clk);
        #1;
        total_cnt++;
        if (o10 !== 1'b0 || u_d10.cnt_q !== 4'd0) begin
            $display("FAIL async_reset_hold: got out=%b cnt=%0d want out=0 cnt=0", o10, u_d10.cnt_q);
        end else pass_cnt++;
        rst = 1'b1;
    endtask

    task automatic test_restart;
        logic exp_v;
        do_reset(3);
        repeat (35) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (o10 !== 1'b0) begin
            $display("FAIL restart_abort: got %b want 0", o10);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            exp_v = ((k % 10) >= 5);
            total_cnt++;
            if (o10 !== exp_v) begin
                $display("FAIL restart_div10 edge %0d: got %b want %b", k, o10, exp_v);
            end else pass_cnt++;
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b0;
        test_reset();
        test_even();
        test_odd();
        test_min_div();
        test_scaled_and_default();
        test_async_mid_high();
        test_restart();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
